constraint_counter_scheduler: RTL and testbench

- Shares a pool of P bounded-repetition counters among R constraint blocks of the NFA engine; constraint instances far outnumber the ones simultaneously active.
- Holds a per-requester configuration table: lower bound N, upper bound M and mode.
- Allocates a free counter slot to a requester on start, steers its increment and release strobes to that slot, and returns per-requester match and overflow flags.

---
 rtl/constraint_counter_scheduler_pkg.sv | 26 ++
 rtl/constraint_slot_counter.sv | 37 +++
 rtl/constraint_counter_scheduler.sv | 159 +++++++++++++++
 tb/tb_constraint_counter_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/constraint_counter_scheduler_pkg.sv
// Shared types for the constraint counter scheduler: bound modes and the
// per-requester configuration entry.
package constraint_counter_scheduler_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        MODE_ATMOST  = 2'd0,
        MODE_BETWEEN = 2'd1,
        MODE_ATLEAST = 2'd2
    } mode_e;

    typedef struct packed {
        logic [CNT_W-1:0] min;
        logic [CNT_W-1:0] max;
        mode_e            mode;
    } cfg_entry_t;

    localparam cfg_entry_t CFG_DEFAULT = '{min: '0, max: '0, mode: MODE_BETWEEN};

    // Encoding 3 is reserved and folds onto the between mode.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        return (raw == 2'd3) ? MODE_BETWEEN : mode_e'(raw);
    endfunction

endpackage

// File: rtl/constraint_slot_counter.sv
// One shared bounded-repetition counter slot: clear, enabled increment,
// saturating at a caller-supplied limit.
module constraint_slot_counter #(
    parameter int unsigned K = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [K-1:0] limit_i,
    output logic [K-1:0] count_o
);

    logic [K-1:0] count_q, count_d;

    // A lowered limit never pulls the count down; it only stops further counting.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && inc_i && (count_q < limit_i)) begin
            count_d = count_q + K'(1);
        end
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/constraint_counter_scheduler.sv
// Shares P bounded-repetition counters among R constraint blocks: config
// table, round-robin slot allocation, strobe steering and bound flags.
module constraint_counter_scheduler
    import constraint_counter_scheduler_pkg::*;
#(
    parameter int unsigned R  = 8,
    parameter int unsigned P  = 4,
    parameter int unsigned K  = CNT_W,  // must equal CNT_W of the entry struct
    parameter int unsigned RW = $clog2(R),
    parameter int unsigned PW = $clog2(P)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [RW-1:0] cfg_idx,
    input  logic [K-1:0]  cfg_min,
    input  logic [K-1:0]  cfg_max,
    input  logic [1:0]    cfg_mode,
    input  logic [R-1:0]  req,
    input  logic [R-1:0]  inc,
    input  logic [R-1:0]  clr,
    output logic [R-1:0]  grant,
    output logic          full,
    output logic [R-1:0]  match,
    output logic [R-1:0]  overflow
);

    cfg_entry_t    cfg_q   [R];
    cfg_entry_t    cfg_d   [R];
    logic [R-1:0]  grant_q, grant_d;
    logic [P-1:0]  busy_q, busy_d;
    logic [RW-1:0] owner_q [P];
    logic [RW-1:0] owner_d [P];
    logic [PW-1:0] slot_q  [R];
    logic [PW-1:0] slot_d  [R];
    logic [RW-1:0] ptr_q, ptr_d;

    logic [P-1:0]  slot_clr, slot_inc;
    logic [K-1:0]  slot_limit [P];
    logic [K-1:0]  slot_count [P];

    logic          found, free_found;
    logic [RW-1:0] winner, idx;
    logic [PW-1:0] free_slot;

    always_comb begin
        cfg_d      = cfg_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        slot_clr   = '0;
        found      = 1'b0;
        winner     = '0;
        idx        = '0;
        free_found = 1'b0;
        free_slot  = '0;

        if (cfg_we) begin
            cfg_d[cfg_idx].min  = cfg_min;
            cfg_d[cfg_idx].max  = (cfg_max == '1) ? {{(K-1){1'b1}}, 1'b0} : cfg_max;
            cfg_d[cfg_idx].mode = decode_mode(cfg_mode);
        end

        for (int unsigned r = 0; r < R; r++) begin
            if (clr[r] && grant_q[r]) begin
                grant_d[r]          = 1'b0;
                busy_d[slot_q[r]]   = 1'b0;
                slot_clr[slot_q[r]] = 1'b1;
            end
        end

        // Search uses registered occupancy, so a slot freed this edge waits one edge.
        for (int unsigned i = 0; i < R; i++) begin
            idx = RW'((32'(ptr_q) + i) % R);
            if (!found && req[idx] && !grant_q[idx] && !clr[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        for (int unsigned p = 0; p < P; p++) begin
            if (!free_found && !busy_q[p]) begin
                free_found = 1'b1;
                free_slot  = PW'(p);
            end
        end

        if (en && found && free_found) begin
            grant_d[winner]    = 1'b1;
            busy_d[free_slot]  = 1'b1;
            owner_d[free_slot] = winner;
            slot_d[winner]     = free_slot;
            slot_clr[free_slot] = 1'b1;
            ptr_d = (32'(winner) == R - 1) ? '0 : winner + RW'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            cfg_q   <= '{default: CFG_DEFAULT};
            grant_q <= '0;
            busy_q  <= '0;
            owner_q <= '{default: '0};
            slot_q  <= '{default: '0};
            ptr_q   <= '0;
        end else begin
            cfg_q   <= cfg_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < P; p++) begin
            slot_inc[p]   = busy_q[p] && inc[owner_q[p]];
            slot_limit[p] = (cfg_q[owner_q[p]].mode == MODE_ATLEAST) ?
                            cfg_q[owner_q[p]].min : cfg_q[owner_q[p]].max + K'(1);
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_slot
        constraint_slot_counter #(.K(K)) u_cnt (
            .clk_i   (clk),
            .rst_i   (rst),
            .en_i    (en),
            .clr_i   (slot_clr[p]),
            .inc_i   (slot_inc[p]),
            .limit_i (slot_limit[p]),
            .count_o (slot_count[p])
        );
    end

    always_comb begin
        match    = '0;
        overflow = '0;
        for (int unsigned r = 0; r < R; r++) begin
            if (grant_q[r]) begin
                unique case (cfg_q[r].mode)
                    MODE_ATMOST:  match[r] = slot_count[slot_q[r]] <= cfg_q[r].max;
                    MODE_BETWEEN: match[r] = (slot_count[slot_q[r]] >= cfg_q[r].min) &&
                                             (slot_count[slot_q[r]] <= cfg_q[r].max);
                    MODE_ATLEAST: match[r] = slot_count[slot_q[r]] >= cfg_q[r].min;
                    default:      match[r] = 1'b0;
                endcase
                overflow[r] = (cfg_q[r].mode != MODE_ATLEAST) &&
                              (slot_count[slot_q[r]] == cfg_q[r].max + K'(1));
            end
        end
    end

    assign grant = grant_q;
    assign full  = &busy_q;

endmodule

// File: tb/tb_constraint_counter_scheduler.sv
// Directed and randomized bench for constraint_counter_scheduler against a
// per-requester behavioural model.
module tb_constraint_counter_scheduler;

    localparam int R = 8;
    localparam int P = 4;
    localparam int K = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         cfg_we = 1'b0;
    logic [2:0]   cfg_idx = '0;
    logic [K-1:0] cfg_min = '0;
    logic [K-1:0] cfg_max = '0;
    logic [1:0]   cfg_mode = '0;
    logic [R-1:0] req = '0;
    logic [R-1:0] inc = '0;
    logic [R-1:0] clr = '0;
    logic [R-1:0] grant, match, overflow;
    logic         full;

    int checks = 0;
    int failures = 0;

    logic [R-1:0] m_g;
    int m_cnt [R];
    int m_min [R];
    int m_max [R];
    int m_mode [R];
    int m_ptr;

    always #5 clk = ~clk;

    constraint_counter_scheduler #(.R(R), .P(P), .K(K), .RW(3), .PW(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .cfg_mode(cfg_mode), .req(req), .inc(inc), .clr(clr),
        .grant(grant), .full(full), .match(match), .overflow(overflow)
    );

    function automatic int limit_of(input int r);
        return (m_mode[r] == 2) ? m_min[r] : m_max[r] + 1;
    endfunction

    task automatic model_edge();
        logic [R-1:0] g0;
        int owned, win, r;
        if (rst) begin
            m_g = '0;
            m_ptr = 0;
            for (int i = 0; i < R; i++) begin
                m_cnt[i] = 0; m_min[i] = 0; m_max[i] = 0; m_mode[i] = 1;
            end
            return;
        end
        g0 = m_g;
        owned = $countones(g0);
        for (int i = 0; i < R; i++) begin
            if (g0[i]) begin
                if (clr[i]) begin
                    m_g[i] = 1'b0;
                    m_cnt[i] = 0;
                end else if (en && inc[i] && m_cnt[i] < limit_of(i)) begin
                    m_cnt[i]++;
                end
            end
        end
        if (en && owned < P) begin
            win = -1;
            for (int k = 0; k < R; k++) begin
                r = (m_ptr + k) % R;
                if (win < 0 && req[r] && !g0[r] && !clr[r]) win = r;
            end
            if (win >= 0) begin
                m_g[win] = 1'b1;
                m_cnt[win] = 0;
                m_ptr = (win + 1) % R;
            end
        end
        if (cfg_we) begin
            m_min[cfg_idx]  = int'(cfg_min);
            m_max[cfg_idx]  = (cfg_max == 8'hFF) ? 254 : int'(cfg_max);
            m_mode[cfg_idx] = (cfg_mode == 2'd3) ? 1 : int'(cfg_mode);
        end
    endtask

    task automatic check(input string tag);
        logic [R-1:0] eg, em, eo;
        logic ef;
        int c;
        eg = m_g; em = '0; eo = '0;
        for (int r = 0; r < R; r++) begin
            if (m_g[r]) begin
                c = m_cnt[r];
                case (m_mode[r])
                    0:       em[r] = (c <= m_max[r]);
                    1:       em[r] = (m_min[r] <= c) && (c <= m_max[r]);
                    default: em[r] = (c >= m_min[r]);
                endcase
                eo[r] = (m_mode[r] != 2) && (c == m_max[r] + 1);
            end
        end
        ef = ($countones(m_g) == P);
        checks++;
        assert (grant === eg) else begin
            failures++; $error("FAIL %s grant got=%b exp=%b", tag, grant, eg);
        end
        checks++;
        assert (full === ef) else begin
            failures++; $error("FAIL %s full got=%b exp=%b", tag, full, ef);
        end
        checks++;
        assert (match === em) else begin
            failures++; $error("FAIL %s match got=%b exp=%b", tag, match, em);
        end
        checks++;
        assert (overflow === eo) else begin
            failures++; $error("FAIL %s overflow got=%b exp=%b", tag, overflow, eo);
        end
    endtask

    // Inputs are driven after posedge; DUT and model both advance on negedge.
    task automatic tick(input string tag);
        @(negedge clk);
        model_edge();
        @(posedge clk);
        check(tag);
        cfg_we = 1'b0; inc = '0; clr = '0;
    endtask

    task automatic cfg(input int idx, input int mn, input int mx, input int md);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_min = K'(mn); cfg_max = K'(mx); cfg_mode = 2'(md);
        tick("cfg");
    endtask

    initial begin
        tick("reset");
        rst = 1'b0; en = 1'b1;

        cfg(2, 3, 3, 1);
        req = 8'h04; tick("grant_r2");
        req = '0;
        for (int i = 0; i < 5; i++) begin
            inc = 8'h04; tick("between_inc");
        end
        clr = 8'h04; tick("release_r2");

        req = 8'h3F;
        for (int i = 0; i < 4; i++) tick("fill");
        req = 8'h30;
        clr = 8'h02; tick("release_r1_same_edge");
        tick("grant_r4_next_edge");
        req = '0;
        clr = '1; tick("release_all");

        cfg(5, 2, 9, 2);
        req = 8'h20; tick("grant_r5");
        req = '0;
        for (int i = 0; i < 5; i++) begin
            inc = 8'h20; tick("atleast_inc");
        end
        inc = 8'h20; clr = 8'h20; tick("clr_beats_inc");

        cfg(3, 0, 5, 0);
        req = 8'h08; tick("grant_r3");
        req = '0;
        inc = 8'h08; tick("inc_en1");
        inc = 8'h08; tick("inc_en1");
        en = 1'b0;
        inc = 8'h08; tick("inc_en0");
        req = 8'h10; inc = 8'h08; tick("req_en0");
        clr = 8'h08; tick("clr_en0");
        en = 1'b1; tick("grant_after_en");
        req = '0; clr = '1; tick("release_all");

        cfg(0, 0, 8'hFF, 0);
        req = 8'h0E;
        for (int i = 0; i < 3; i++) tick("rot_fill");
        req = 8'h80; tick("grant_r7");
        req = '0; clr = 8'h80; tick("release_r7");
        req = 8'h41; tick("r0_beats_r6");
        req = '0;
        for (int i = 0; i < 256; i++) begin
            inc = 8'h01; tick("max_ff");
        end

        clr = 8'h08; tick("drop_to_three");
        inc = 8'h06; tick("count_mid");
        rst = 1'b1; inc = 8'h06; req = 8'hF0; tick("mid_reset");
        rst = 1'b0; req = 8'h04; tick("default_grant");
        req = '0; inc = 8'h04; tick("default_overflow");
        clr = '1; tick("release_all");

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) != 0);
            req = 8'($urandom);
            inc = 8'($urandom);
            clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1;
                cfg_idx = 3'($urandom);
                cfg_min = 8'($urandom_range(0, 6));
                cfg_max = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                cfg_mode = 2'($urandom);
            end
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
